// File: rtl/switch_repeat_gen_if.sv
// rtl/switch_repeat_gen_if.sv - switch level / move strobe bundle for switch_repeat_gen
interface switch_repeat_gen_if #(
  parameter int NUM_SWITCHES = 4
);
  logic [NUM_SWITCHES-1:0] i_Switch;
  logic                    i_Repeat_En;
  logic [NUM_SWITCHES-1:0] o_Pulse;
  logic [NUM_SWITCHES-1:0] o_Held;

  modport master (
    output i_Switch,
    output i_Repeat_En,
    input  o_Pulse,
    input  o_Held
  );

  modport slave (
    input  i_Switch,
    input  i_Repeat_En,
    output o_Pulse,
    output o_Held
  );
endinterface

// File: rtl/switch_repeat_gen.sv
// rtl/switch_repeat_gen.sv - N-channel key auto-repeat strobe generator, one FSM and counter per channel
// Optional macro SWITCH_REPEAT_LOCKOUT_EN: only one channel at a time may leave IDLE (lowest index wins).
module switch_repeat_gen #(
  parameter int          NUM_SWITCHES  = 4,
  parameter int          CNT_WIDTH     = 32,
  parameter int unsigned INITIAL_DELAY = 12500000,
  parameter int unsigned REPEAT_PERIOD = 1250000
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  switch_repeat_gen_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT,
    ST_HELD
  } state_t;

  localparam longint unsigned      CNT_SPAN    = 64'd1 << CNT_WIDTH;
  localparam logic [CNT_WIDTH-1:0] DELAY_LAST  = CNT_WIDTH'(INITIAL_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] REPEAT_LAST = CNT_WIDTH'(REPEAT_PERIOD - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

  if (INITIAL_DELAY == 0 || {32'd0, INITIAL_DELAY} >= CNT_SPAN) begin : g_bad_delay
    $fatal(1, "switch_repeat_gen: INITIAL_DELAY must be in 1 .. 2**CNT_WIDTH-1");
  end
  if (REPEAT_PERIOD == 0 || {32'd0, REPEAT_PERIOD} >= CNT_SPAN) begin : g_bad_period
    $fatal(1, "switch_repeat_gen: REPEAT_PERIOD must be in 1 .. 2**CNT_WIDTH-1");
  end

  state_t                  state_q [NUM_SWITCHES];
  logic [CNT_WIDTH-1:0]    cnt_q   [NUM_SWITCHES];
  logic [NUM_SWITCHES-1:0] pulse_q;
  logic [NUM_SWITCHES-1:0] held_q;
  logic [NUM_SWITCHES-1:0] idle_mask;
  logic [NUM_SWITCHES-1:0] press_req;
  logic [NUM_SWITCHES-1:0] grant;

  always_comb begin
    idle_mask = '0;
    for (int k = 0; k < NUM_SWITCHES; k++) begin
      idle_mask[k] = (state_q[k] == ST_IDLE);
    end
    press_req = bus.i_Switch & idle_mask;
  end

`ifdef SWITCH_REPEAT_LOCKOUT_EN
  localparam int IDX_W = (NUM_SWITCHES > 1) ? $clog2(NUM_SWITCHES) : 1;

  logic             owner_valid_q;
  logic [IDX_W-1:0] owner_idx_q;
  logic [IDX_W-1:0] claim_idx;

  // While an owner exists every other channel is IDLE, so the lowest pressed idle channel claims.
  always_comb begin
    grant     = '0;
    claim_idx = '0;
    for (int k = NUM_SWITCHES - 1; k >= 0; k--) begin
      if (press_req[k]) begin
        claim_idx = IDX_W'(k);
      end
    end
    if (!owner_valid_q && |press_req) begin
      grant[claim_idx] = 1'b1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      owner_valid_q <= 1'b0;
      owner_idx_q   <= '0;
    end else if (owner_valid_q) begin
      if (!bus.i_Switch[owner_idx_q]) begin
        owner_valid_q <= 1'b0;
      end
    end else if (|press_req) begin
      owner_valid_q <= 1'b1;
      owner_idx_q   <= claim_idx;
    end
  end
`else
  always_comb begin
    grant = press_req;
  end
`endif

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      pulse_q <= '0;
      held_q  <= '0;
      for (int k = 0; k < NUM_SWITCHES; k++) begin
        state_q[k] <= ST_IDLE;
        cnt_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_SWITCHES; k++) begin
        pulse_q[k] <= 1'b0;
        case (state_q[k])
          ST_IDLE: begin
            if (grant[k]) begin
              pulse_q[k] <= 1'b1;
              held_q[k]  <= 1'b1;
              cnt_q[k]   <= '0;
              state_q[k] <= bus.i_Repeat_En ? ST_DELAY : ST_HELD;
            end
          end
          ST_DELAY, ST_REPEAT: begin
            // Release beats an enable drop, which beats a terminal count.
            if (!bus.i_Switch[k]) begin
              state_q[k] <= ST_IDLE;
              held_q[k]  <= 1'b0;
              cnt_q[k]   <= '0;
            end else if (!bus.i_Repeat_En) begin
              state_q[k] <= ST_HELD;
              cnt_q[k]   <= '0;
            end else if (cnt_q[k] == ((state_q[k] == ST_DELAY) ? DELAY_LAST : REPEAT_LAST)) begin
              pulse_q[k] <= 1'b1;
              cnt_q[k]   <= '0;
              state_q[k] <= ST_REPEAT;
            end else begin
              cnt_q[k] <= cnt_q[k] + CNT_ONE;
            end
          end
          ST_HELD: begin
            cnt_q[k] <= '0;
            if (!bus.i_Switch[k]) begin
              state_q[k] <= ST_IDLE;
              held_q[k]  <= 1'b0;
            end else if (bus.i_Repeat_En) begin
              state_q[k] <= ST_DELAY;
            end
          end
          default: begin
            state_q[k] <= ST_IDLE;
            held_q[k]  <= 1'b0;
            cnt_q[k]   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.o_Pulse = pulse_q;
  assign bus.o_Held  = held_q;

endmodule

// File: tb/tb_switch_repeat_gen.sv
// tb/tb_switch_repeat_gen.sv - randomized bench for switch_repeat_gen against a pulse-schedule model
module tb_switch_repeat_gen;

  logic       clk;
  logic       rst;
  logic [3:0] sw;
  logic       en;

  int total = 0;
  int bad   = 0;
  int n     = 0;

  int         active [2][4];
  int         nxt    [2][4];
  int         owner  [2];
  logic [3:0] exp_p  [2];
  logic [3:0] exp_h  [2];

  int cnt_a0, cnt_a1, cnt_a2, cnt_b0;

  switch_repeat_gen_if #(.NUM_SWITCHES(4)) bus_a ();
  switch_repeat_gen_if #(.NUM_SWITCHES(4)) bus_b ();

  switch_repeat_gen #(
    .NUM_SWITCHES(4), .CNT_WIDTH(32), .INITIAL_DELAY(10), .REPEAT_PERIOD(4)
  ) u_dut_a (
    .i_Clk(clk), .i_Reset(rst), .bus(bus_a.slave)
  );

  switch_repeat_gen #(
    .NUM_SWITCHES(4), .CNT_WIDTH(8), .INITIAL_DELAY(1), .REPEAT_PERIOD(1)
  ) u_dut_b (
    .i_Clk(clk), .i_Reset(rst), .bus(bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s edge=%0d got=%0h want=%0h", tag, n, got, want);
    end
  endtask

  // A held channel is a schedule: the next edge number at which a repeat strobe is due (-1 = none).
  task automatic model_step(input int d, input int id, input int rp);
`ifdef SWITCH_REPEAT_LOCKOUT_EN
    int own0;
    int first;
`endif
    exp_p[d] = '0;
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        active[d][k] = 0;
        nxt[d][k]    = -1;
      end
      owner[d] = -1;
    end else begin
`ifdef SWITCH_REPEAT_LOCKOUT_EN
      own0  = owner[d];
      first = -1;
      for (int k = 3; k >= 0; k--) if (sw[k]) first = k;
`endif
      for (int k = 0; k < 4; k++) begin
        if (active[d][k] == 0) begin
`ifdef SWITCH_REPEAT_LOCKOUT_EN
          if (sw[k] && own0 == -1 && first == k) begin
            owner[d] = k;
`else
          if (sw[k]) begin
`endif
            active[d][k] = 1;
            exp_p[d][k]  = 1'b1;
            nxt[d][k]    = en ? n + id : -1;
          end
        end else if (!sw[k]) begin
          active[d][k] = 0;
          nxt[d][k]    = -1;
          if (owner[d] == k) owner[d] = -1;
        end else if (!en) begin
          nxt[d][k] = -1;
        end else if (nxt[d][k] == -1) begin
          nxt[d][k] = n + id;
        end else if (nxt[d][k] == n) begin
          exp_p[d][k] = 1'b1;
          nxt[d][k]   = n + rp;
        end
      end
    end
    for (int k = 0; k < 4; k++) exp_h[d][k] = (active[d][k] != 0);
  endtask

  task automatic cycle(input logic r, input logic [3:0] s, input logic e);
    rst = r;
    sw  = s;
    en  = e;
    bus_a.i_Switch    = s;
    bus_a.i_Repeat_En = e;
    bus_b.i_Switch    = s;
    bus_b.i_Repeat_En = e;
    @(posedge clk);
    model_step(0, 10, 4);
    model_step(1, 1, 1);
    #1;
    chk("a_pulse", 32'(bus_a.o_Pulse), 32'(exp_p[0]));
    chk("a_held",  32'(bus_a.o_Held),  32'(exp_h[0]));
    chk("b_pulse", 32'(bus_b.o_Pulse), 32'(exp_p[1]));
    chk("b_held",  32'(bus_b.o_Held),  32'(exp_h[1]));
    cnt_a0 += int'(bus_a.o_Pulse[0]);
    cnt_a1 += int'(bus_a.o_Pulse[1]);
    cnt_a2 += int'(bus_a.o_Pulse[2]);
    cnt_b0 += int'(bus_b.o_Pulse[0]);
    n++;
  endtask

  task automatic clear_counts();
    cnt_a0 = 0;
    cnt_a1 = 0;
    cnt_a2 = 0;
    cnt_b0 = 0;
  endtask

  initial begin
    logic [3:0] s;
    logic       e;
    logic       r;
    owner[0] = -1;
    owner[1] = -1;
    clear_counts();

    repeat (3) cycle(1'b1, 4'b0000, 1'b1);
    repeat (2) cycle(1'b0, 4'b0000, 1'b1);

    clear_counts();
    repeat (30) cycle(1'b0, 4'b0001, 1'b1);
    chk("hold_a0_pulses", 32'(cnt_a0), 32'd6);
    chk("hold_b0_pulses", 32'(cnt_b0), 32'd30);
    repeat (3) cycle(1'b0, 4'b0000, 1'b1);

    clear_counts();
    repeat (3) cycle(1'b0, 4'b0100, 1'b1);
    repeat (3) cycle(1'b0, 4'b0000, 1'b1);
    chk("tap_a2_pulses", 32'(cnt_a2), 32'd1);

    clear_counts();
    repeat (20) cycle(1'b0, 4'b0010, 1'b0);
    chk("noen_a1_pulses", 32'(cnt_a1), 32'd1);
    repeat (15) cycle(1'b0, 4'b0010, 1'b1);
    chk("reen_a1_pulses", 32'(cnt_a1), 32'd3);
    repeat (15) cycle(1'b0, 4'b0010, 1'b0);
    repeat (3) cycle(1'b0, 4'b0000, 1'b1);

    repeat (3) cycle(1'b0, 4'b0001, 1'b1);
    repeat (25) cycle(1'b0, 4'b1001, 1'b1);
    repeat (3) cycle(1'b0, 4'b0000, 1'b1);

    repeat (12) cycle(1'b0, 4'b0001, 1'b1);
    cycle(1'b1, 4'b0001, 1'b1);
    repeat (20) cycle(1'b0, 4'b0001, 1'b1);
    repeat (3) cycle(1'b0, 4'b0000, 1'b1);

    repeat (20) cycle(1'b0, 4'b0110, 1'b1);
    repeat (10) cycle(1'b0, 4'b0100, 1'b1);
    repeat (3) cycle(1'b0, 4'b0000, 1'b1);

    s = 4'b0000;
    e = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(15) == 0) s[k] = ~s[k];
      end
      if ($urandom_range(63) == 0) e = ~e;
      r = ($urandom_range(499) == 0);
      cycle(r, s, e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
